// File: rtl/spi_cmd_pkg.sv
// Shared types and constants for the SPI command dispatcher.
package spi_cmd_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DECODE = 2'd1,
      ISSUE  = 2'd2
   } state_t;

   localparam logic [7:0] OPC_NOP = 8'h00;

   // Opcode bits that select the execution unit.
   localparam int unsigned UNIT_MSB = 7;
   localparam int unsigned UNIT_LSB = 6;

   localparam int unsigned FUNC_W = 6;
   localparam int unsigned DATA_W = 80;
   localparam int unsigned CMD_W  = 88;

endpackage

// File: rtl/spi_cmd_queue.sv
// Single-clock show-ahead FIFO holding {opcode, cmd_data} frames.
module spi_cmd_queue #(
   parameter int unsigned WIDTH = 88,
   parameter int unsigned DEPTH = 4
) (
   input  logic                       clk_sys,
   input  logic                       rstb,
   input  logic                       push,
   input  logic                       pop,
   input  logic [WIDTH-1:0]           din,
   output logic [WIDTH-1:0]           dout,
   output logic [$clog2(DEPTH):0]     level,
   output logic                       full,
   output logic                       empty
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0]   FULL_LVL = (AW+1)'(DEPTH);
   localparam logic [AW:0]   ONE_LVL  = (AW+1)'(1);
   localparam logic [AW-1:0] ONE_PTR  = AW'(1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      level_q;
   logic             do_push;
   logic             do_pop;

   assign full    = (level_q == FULL_LVL);
   assign empty   = (level_q == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign dout    = mem[rd_ptr];
   assign level   = level_q;

   // Storage array; no reset needed since empty entries are never read.
   always_ff @(posedge clk_sys) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   // Pointers wrap naturally at the power-of-2 depth; level tracks occupancy.
   always_ff @(posedge clk_sys or negedge rstb) begin
      if (!rstb) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         level_q <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + ONE_PTR;
         if (do_pop)  rd_ptr <= rd_ptr + ONE_PTR;
         case ({do_push, do_pop})
            2'b10:   level_q <= level_q + ONE_LVL;
            2'b01:   level_q <= level_q - ONE_LVL;
            default: level_q <= level_q;
         endcase
      end
   end

endmodule

// File: rtl/spi_cmd_dispatch.sv
// In-order command scheduler: queues SPI frames, decodes the target unit,
// and issues one command at a time over a one-hot req/ack handshake.
module spi_cmd_dispatch
   import spi_cmd_pkg::*;
#(
   parameter int unsigned QUEUE_DEPTH    = 4,
   parameter int unsigned NUM_UNITS      = 4,
   parameter logic [3:0]  UNIT_MASK      = 4'b1111,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic                           clk_sys,
   input  logic                           rstb,
   input  logic                           cmd_valid,
   input  logic [7:0]                     opcode,
   input  logic [79:0]                    cmd_data,
   output logic [NUM_UNITS-1:0]           exec_req,
   output logic [5:0]                     exec_func,
   output logic [79:0]                    exec_data,
   input  logic [NUM_UNITS-1:0]           exec_ack,
   output logic                           done,
   output logic                           busy,
   output logic [$clog2(QUEUE_DEPTH):0]   q_level,
   output logic                           overflow,
   output logic [7:0]                     err_cnt,
   output logic [7:0]                     to_cnt,
   input  logic                           clr_status
);

   // Last ISSUE count value before the limit is reached on the next edge.
   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

   state_t                state_q, state_d;
   logic [CMD_W-1:0]      q_dout;
   logic [CMD_W-1:0]      cmd_reg;
   logic                  q_full, q_empty, q_push, q_pop;
   logic [7:0]            cmd_opc;
   logic [1:0]            unit;
   logic                  unit_ok;
   logic [NUM_UNITS-1:0]  req_onehot;
   logic [NUM_UNITS-1:0]  req_q;
   logic [FUNC_W-1:0]     func_q;
   logic [DATA_W-1:0]     data_q;
   logic [7:0]            tmo_q;
   logic [7:0]            err_q, to_q;
   logic                  done_q, ovf_q;
   logic                  load_cmd, start_issue, ack_hit, tmo_hit, dec_err;

   // Full is evaluated before any same-cycle pop, so a full queue always drops.
   assign q_push = cmd_valid & ~q_full;

   spi_cmd_queue #(
      .WIDTH (CMD_W),
      .DEPTH (QUEUE_DEPTH)
   ) u_queue (
      .clk_sys (clk_sys),
      .rstb    (rstb),
      .push    (q_push),
      .pop     (q_pop),
      .din     ({opcode, cmd_data}),
      .dout    (q_dout),
      .level   (q_level),
      .full    (q_full),
      .empty   (q_empty)
   );

   assign cmd_opc = cmd_reg[CMD_W-1 -: 8];
   assign unit    = cmd_opc[UNIT_MSB:UNIT_LSB];

   // Unit presence check and one-hot request vector for the decoded unit.
   always_comb begin
      unit_ok    = 1'b0;
      req_onehot = '0;
      if (32'(unit) < NUM_UNITS) unit_ok = UNIT_MASK[unit];
      for (int unsigned u = 0; u < NUM_UNITS; u++) begin
         req_onehot[u] = (32'(unit) == u);
      end
   end

   // FSM state register.
   always_ff @(posedge clk_sys or negedge rstb) begin
      if (!rstb) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Next-state logic and per-cycle action strobes.
   always_comb begin
      state_d     = state_q;
      load_cmd    = 1'b0;
      start_issue = 1'b0;
      ack_hit     = 1'b0;
      tmo_hit     = 1'b0;
      dec_err     = 1'b0;
      case (state_q)
         IDLE: begin
            if (!q_empty) begin
               load_cmd = 1'b1;
               state_d  = DECODE;
            end
         end
         DECODE: begin
            if (cmd_opc == OPC_NOP) begin
               state_d = IDLE;
            end else if (!unit_ok) begin
               dec_err = 1'b1;
               state_d = IDLE;
            end else begin
               start_issue = 1'b1;
               state_d     = ISSUE;
            end
         end
         ISSUE: begin
            // Ack is checked first so it wins over a coincident timeout.
            if (|(exec_ack & req_q)) begin
               ack_hit = 1'b1;
               state_d = IDLE;
            end else if (tmo_q == TMO_LAST) begin
               tmo_hit = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign q_pop = load_cmd;

   // Command register, issue outputs, timeout counter and done pulse.
   always_ff @(posedge clk_sys or negedge rstb) begin
      if (!rstb) begin
         cmd_reg <= '0;
         req_q   <= '0;
         func_q  <= '0;
         data_q  <= '0;
         tmo_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         done_q <= ack_hit;
         if (load_cmd) cmd_reg <= q_dout;
         if (start_issue) begin
            req_q  <= req_onehot;
            func_q <= cmd_opc[FUNC_W-1:0];
            data_q <= cmd_reg[DATA_W-1:0];
            tmo_q  <= '0;
         end else if (ack_hit || tmo_hit) begin
            req_q <= '0;
         end else if (state_q == ISSUE) begin
            tmo_q <= tmo_q + 8'd1;
         end
      end
   end

   // Sticky/saturating status; a clear in the same cycle as an event wins.
   always_ff @(posedge clk_sys or negedge rstb) begin
      if (!rstb) begin
         ovf_q <= 1'b0;
         err_q <= '0;
         to_q  <= '0;
      end else if (clr_status) begin
         ovf_q <= 1'b0;
         err_q <= '0;
         to_q  <= '0;
      end else begin
         if (cmd_valid && q_full)        ovf_q <= 1'b1;
         if (dec_err && (err_q != '1))   err_q <= err_q + 8'd1;
         if (tmo_hit && (to_q != '1))    to_q  <= to_q + 8'd1;
      end
   end

   assign exec_req  = req_q;
   assign exec_func = func_q;
   assign exec_data = data_q;
   assign done      = done_q;
   assign busy      = (state_q != IDLE) || !q_empty;
   assign overflow  = ovf_q;
   assign err_cnt   = err_q;
   assign to_cnt    = to_q;

endmodule

// File: tb/tb_spi_cmd_dispatch.sv
// Self-checking bench for spi_cmd_dispatch (unit 3 absent, 10-cycle timeout).
module tb_spi_cmd_dispatch;

   localparam logic [3:0] MASK_TB = 4'b0111;
   localparam int         NUNITS  = 4;
   localparam int         TMO     = 10;

   logic        clk_sys = 1'b0;
   logic        rstb = 1'b0;
   logic        cmd_valid = 1'b0;
   logic [7:0]  opcode = '0;
   logic [79:0] cmd_data = '0;
   logic [3:0]  exec_ack = '0;
   logic        clr_status = 1'b0;
   logic [3:0]  exec_req;
   logic [5:0]  exec_func;
   logic [79:0] exec_data;
   logic        done, busy, overflow;
   logic [2:0]  q_level;
   logic [7:0]  err_cnt, to_cnt;

   int checks = 0;
   int failures = 0;
   int hi_cycles = 0;
   int done_cnt = 0;
   int exp_err = 0;
   int exp_to = 0;

   spi_cmd_dispatch #(
      .QUEUE_DEPTH    (4),
      .NUM_UNITS      (4),
      .UNIT_MASK      (MASK_TB),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clk_sys    (clk_sys),
      .rstb       (rstb),
      .cmd_valid  (cmd_valid),
      .opcode     (opcode),
      .cmd_data   (cmd_data),
      .exec_req   (exec_req),
      .exec_func  (exec_func),
      .exec_data  (exec_data),
      .exec_ack   (exec_ack),
      .done       (done),
      .busy       (busy),
      .q_level    (q_level),
      .overflow   (overflow),
      .err_cnt    (err_cnt),
      .to_cnt     (to_cnt),
      .clr_status (clr_status)
   );

   always #5 clk_sys = ~clk_sys;

   // Activity monitor sampled 2 time units after each rising edge.
   always @(posedge clk_sys) begin
      #2;
      if (exec_req != 4'b0) hi_cycles++;
      if (done) done_cnt++;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got time=%0t required<200000", $time);
      $fatal(1, "watchdog");
   end

   function automatic logic [79:0] rand_data();
      logic [95:0] t;
      t = {$urandom, $urandom, $urandom};
      return t[79:0];
   endfunction

   // Drive one cmd_valid pulse; returns at the falling edge after it was sampled.
   task automatic send(input logic [7:0] op, input logic [79:0] dat);
      cmd_valid = 1'b1;
      opcode    = op;
      cmd_data  = dat;
      @(negedge clk_sys);
      cmd_valid = 1'b0;
   endtask

   task automatic wait_req(input int bound, output bit found);
      int n;
      found = 1'b0;
      n = 0;
      while (!found && n < bound) begin
         @(negedge clk_sys);
         n++;
         if (exec_req != 4'b0) found = 1'b1;
      end
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk_sys);
      checks++;
      if ({exec_req, done, busy, q_level, overflow, err_cnt, to_cnt, exec_func} !== '0) begin
         failures++;
         $display("FAIL reset_ctrl got req=%b done=%b busy=%b lvl=%0d ovf=%b err=%0d to=%0d func=%h required all 0",
                  exec_req, done, busy, q_level, overflow, err_cnt, to_cnt, exec_func);
      end
      checks++;
      if (exec_data !== '0) begin
         failures++;
         $display("FAIL reset_data got=%h required=0", exec_data);
      end
      rstb = 1'b1;
      @(negedge clk_sys);
   endtask

   task automatic test_single();
      logic [79:0] dat;
      int d0;
      dat = rand_data();
      dat[15:0] = 16'hBEEF;
      send(8'h45, dat);
      checks++;
      if (q_level !== 3'd1 || exec_req !== 4'b0) begin
         failures++;
         $display("FAIL single_e0 got lvl=%0d req=%b required lvl=1 req=0000", q_level, exec_req);
      end
      @(negedge clk_sys);
      checks++;
      if (exec_req !== 4'b0 || q_level !== 3'd0) begin
         failures++;
         $display("FAIL single_e1 got req=%b lvl=%0d required req=0000 lvl=0", exec_req, q_level);
      end
      @(negedge clk_sys);
      checks++;
      if (exec_req !== 4'b0010 || exec_func !== 6'h05 || exec_data !== dat) begin
         failures++;
         $display("FAIL single_issue got req=%b func=%h data=%h required req=0010 func=05 data=%h",
                  exec_req, exec_func, exec_data, dat);
      end
      repeat (2) @(negedge clk_sys);
      d0 = done_cnt;
      exec_ack = 4'b0010;
      @(negedge clk_sys);
      exec_ack = 4'b0;
      checks++;
      if (exec_req !== 4'b0 || done !== 1'b1) begin
         failures++;
         $display("FAIL single_ack got req=%b done=%b required req=0000 done=1", exec_req, done);
      end
      @(negedge clk_sys);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || done_cnt - d0 != 1) begin
         failures++;
         $display("FAIL single_end got done=%b busy=%b pulses=%0d required done=0 busy=0 pulses=1",
                  done, busy, done_cnt - d0);
      end
   endtask

   task automatic test_back_to_back();
      bit found;
      int d0;
      logic [79:0] dat;
      d0 = done_cnt;
      send(8'h40, rand_data());
      wait_req(4, found);
      checks++;
      if (!found || exec_func !== 6'h00) begin
         failures++;
         $display("FAIL b2b_blocker got found=%0d func=%h required found=1 func=00", found, exec_func);
      end
      for (int k = 1; k <= 5; k++) begin
         dat = rand_data();
         dat[15:0] = 16'(k);
         send(8'(8'h40 + k), dat);
      end
      checks++;
      if (q_level !== 3'd4 || overflow !== 1'b1) begin
         failures++;
         $display("FAIL b2b_full got lvl=%0d ovf=%b required lvl=4 ovf=1", q_level, overflow);
      end
      clr_status = 1'b1;
      @(negedge clk_sys);
      clr_status = 1'b0;
      checks++;
      if (overflow !== 1'b0) begin
         failures++;
         $display("FAIL b2b_clr got ovf=%b required 0", overflow);
      end
      exec_ack = 4'b0010;
      @(negedge clk_sys);
      exec_ack = 4'b0;
      // This push lands on the same edge as the pop of a full queue.
      send(8'h46, rand_data());
      checks++;
      if (overflow !== 1'b1 || q_level !== 3'd3) begin
         failures++;
         $display("FAIL b2b_push_at_pop got ovf=%b lvl=%0d required ovf=1 lvl=3", overflow, q_level);
      end
      clr_status = 1'b1;
      @(negedge clk_sys);
      clr_status = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         wait_req(6, found);
         checks++;
         if (!found || exec_req !== 4'b0010 || exec_func !== 6'(k) || exec_data[15:0] !== 16'(k)) begin
            failures++;
            $display("FAIL b2b_order%0d got found=%0d req=%b func=%h w0=%h required req=0010 func=%h w0=%h",
                     k, found, exec_req, exec_func, exec_data[15:0], 6'(k), 16'(k));
         end
         exec_ack = 4'b0010;
         @(negedge clk_sys);
         exec_ack = 4'b0;
      end
      repeat (4) @(negedge clk_sys);
      checks++;
      if (exec_req !== 4'b0 || q_level !== 3'd0 || busy !== 1'b0 || overflow !== 1'b0 || done_cnt - d0 != 5) begin
         failures++;
         $display("FAIL b2b_drain got req=%b lvl=%0d busy=%b ovf=%b pulses=%0d required 0000/0/0/0/5",
                  exec_req, q_level, busy, overflow, done_cnt - d0);
      end
   endtask

   task automatic test_errors();
      int h0, d0;
      h0 = hi_cycles;
      d0 = done_cnt;
      send(8'hC2, rand_data());
      exp_err++;
      repeat (4) @(negedge clk_sys);
      checks++;
      if (hi_cycles != h0 || err_cnt !== 8'(exp_err)) begin
         failures++;
         $display("FAIL err_absent got req_cycles=%0d err=%0d required req_cycles=0 err=%0d",
                  hi_cycles - h0, err_cnt, exp_err);
      end
      send(8'h00, rand_data());
      repeat (4) @(negedge clk_sys);
      checks++;
      if (hi_cycles != h0 || err_cnt !== 8'(exp_err) || done_cnt != d0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL err_nop got req_cycles=%0d err=%0d pulses=%0d busy=%b required 0/%0d/0/0",
                  hi_cycles - h0, err_cnt, done_cnt - d0, busy, exp_err);
      end
   endtask

   task automatic test_timeout();
      bit found;
      int n, d0;
      d0 = done_cnt;
      send(8'h01, rand_data());
      send(8'h02, rand_data());
      wait_req(4, found);
      checks++;
      if (!found || exec_req !== 4'b0001 || exec_func !== 6'h01) begin
         failures++;
         $display("FAIL tmo_issue got req=%b func=%h required req=0001 func=01", exec_req, exec_func);
      end
      n = 1;
      while (exec_req != 4'b0 && n < 20) begin
         @(negedge clk_sys);
         if (exec_req != 4'b0) n++;
      end
      exp_to++;
      checks++;
      if (n != TMO || to_cnt !== 8'(exp_to) || done_cnt != d0) begin
         failures++;
         $display("FAIL tmo_expire got req_cycles=%0d to=%0d pulses=%0d required %0d/%0d/0",
                  n, to_cnt, done_cnt - d0, TMO, exp_to);
      end
      wait_req(4, found);
      checks++;
      if (!found || exec_req !== 4'b0001 || exec_func !== 6'h02) begin
         failures++;
         $display("FAIL tmo_next got req=%b func=%h required req=0001 func=02", exec_req, exec_func);
      end
      exec_ack = 4'b0001;
      @(negedge clk_sys);
      exec_ack = 4'b0;
      checks++;
      if (done !== 1'b1 || exec_req !== 4'b0) begin
         failures++;
         $display("FAIL tmo_next_done got done=%b req=%b required done=1 req=0000", done, exec_req);
      end
   endtask

   task automatic test_stray_ack();
      bit found;
      @(negedge clk_sys);
      exec_ack = 4'b1111;
      @(negedge clk_sys);
      exec_ack = 4'b0;
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || exec_req !== 4'b0) begin
         failures++;
         $display("FAIL stray_idle got done=%b busy=%b req=%b required 0/0/0000", done, busy, exec_req);
      end
      send(8'h03, rand_data());
      wait_req(4, found);
      exec_ack = 4'b0100;
      @(negedge clk_sys);
      exec_ack = 4'b0;
      checks++;
      if (!found || exec_req !== 4'b0001 || done !== 1'b0) begin
         failures++;
         $display("FAIL stray_other got req=%b done=%b required req=0001 done=0", exec_req, done);
      end
      exec_ack = 4'b0001;
      @(negedge clk_sys);
      exec_ack = 4'b0;
      checks++;
      if (exec_req !== 4'b0 || done !== 1'b1) begin
         failures++;
         $display("FAIL stray_complete got req=%b done=%b required req=0000 done=1", exec_req, done);
      end
   endtask

   // Random frames against a rule-level model of decode, ack timing and timeout.
   task automatic test_random();
      bit found;
      logic [7:0]  op;
      logic [79:0] dat;
      logic [3:0]  sel;
      int unit, kind, d, h0, d0, exp_hi, exp_done, n;
      for (int i = 0; i < 24; i++) begin
         op = 8'($urandom);
         if ($urandom_range(0, 7) == 0) op = 8'h00;
         dat  = rand_data();
         unit = int'(op[7:6]);
         if (op == 8'h00)                              kind = 0;
         else if (unit >= NUNITS || MASK_TB[unit] == 1'b0) kind = 1;
         else                                          kind = 2;
         d = (i == 0) ? 9 : (i == 1) ? 10 : int'($urandom_range(0, 12));
         if (i < 2) begin
            op[7:6] = 2'd2;
            unit = 2;
            kind = 2;
         end
         h0 = hi_cycles;
         d0 = done_cnt;
         send(op, dat);
         exp_hi = 0;
         exp_done = 0;
         if (kind == 2) begin
            sel = 4'b0001 << unit;
            wait_req(4, found);
            checks++;
            if (!found || exec_req !== sel || exec_func !== op[5:0] || exec_data !== dat) begin
               failures++;
               $display("FAIL rnd%0d_issue got req=%b func=%h data=%h required req=%b func=%h data=%h",
                        i, exec_req, exec_func, exec_data, sel, op[5:0], dat);
            end
            for (int k = 0; k < d; k++) begin
               exec_ack = 4'($urandom) & ~sel;
               @(negedge clk_sys);
            end
            exec_ack = sel | (4'($urandom) & ~sel);
            @(negedge clk_sys);
            exec_ack = 4'b0;
            n = 0;
            while (exec_req != 4'b0 && n < 15) begin
               @(negedge clk_sys);
               n++;
            end
            repeat (2) @(negedge clk_sys);
            if (d < TMO) begin
               exp_hi = d + 1;
               exp_done = 1;
            end else begin
               exp_hi = TMO;
               if (exp_to < 255) exp_to++;
            end
         end else begin
            repeat (4) @(negedge clk_sys);
            if (kind == 1 && exp_err < 255) exp_err++;
         end
         checks++;
         if (hi_cycles - h0 != exp_hi || done_cnt - d0 != exp_done ||
             err_cnt !== 8'(exp_err) || to_cnt !== 8'(exp_to)) begin
            failures++;
            $display("FAIL rnd%0d_result op=%h d=%0d got req_cycles=%0d pulses=%0d err=%0d to=%0d required %0d/%0d/%0d/%0d",
                     i, op, d, hi_cycles - h0, done_cnt - d0, err_cnt, to_cnt,
                     exp_hi, exp_done, exp_err, exp_to);
         end
      end
   endtask

   task automatic test_reset_mid();
      bit found;
      send(8'h04, rand_data());
      wait_req(4, found);
      send(8'h05, rand_data());
      send(8'h06, rand_data());
      checks++;
      if (!found || exec_req !== 4'b0001 || q_level !== 3'd2) begin
         failures++;
         $display("FAIL rstmid_setup got req=%b lvl=%0d required req=0001 lvl=2", exec_req, q_level);
      end
      #2 rstb = 1'b0;
      #1;
      exp_err = 0;
      exp_to = 0;
      checks++;
      if ({exec_req, done, busy, q_level, overflow, err_cnt, to_cnt, exec_func} !== '0 || exec_data !== '0) begin
         failures++;
         $display("FAIL rstmid_async got req=%b done=%b busy=%b lvl=%0d ovf=%b err=%0d to=%0d func=%h required all 0",
                  exec_req, done, busy, q_level, overflow, err_cnt, to_cnt, exec_func);
      end
      @(negedge clk_sys);
      rstb = 1'b1;
      @(negedge clk_sys);
      send(8'h47, rand_data());
      @(negedge clk_sys);
      checks++;
      if (exec_req !== 4'b0) begin
         failures++;
         $display("FAIL rstmid_early got req=%b required 0000", exec_req);
      end
      @(negedge clk_sys);
      checks++;
      if (exec_req !== 4'b0010 || exec_func !== 6'h07) begin
         failures++;
         $display("FAIL rstmid_issue got req=%b func=%h required req=0010 func=07", exec_req, exec_func);
      end
      exec_ack = 4'b0010;
      @(negedge clk_sys);
      exec_ack = 4'b0;
      checks++;
      if (done !== 1'b1 || exec_req !== 4'b0) begin
         failures++;
         $display("FAIL rstmid_done got done=%b req=%b required done=1 req=0000", done, exec_req);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_errors();
      test_timeout();
      test_stray_ack();
      test_random();
      test_reset_mid();
      repeat (2) @(negedge clk_sys);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
